exception_ctrl: RTL and testbench
=================================

// Module: exception_ctrl
// PURPOSE
//  Consumer side of the hazard unit's exception report (Exception_Caught/Cause). Latches the
//  faulting PC and cause, sequences the pipeline flush, redirects fetch to the handler vector,
//  and on return-from-exception restores the PC from EPC. Sits between the hazard unit and PC mux.
// PARAMETERS
//  DW           16       datapath / PC width
//  VEC_OVF      16'hFF00 handler address for cause 0 (arithmetic overflow)
//  VEC_OPC      16'hFF80 handler address for cause 1 (illegal opcode)
//  FLUSH_CYCLES 2        cycles flush is held (1..7)
// PORTS
//  clk          in  1   clock, rising edge
//  rst          in  1   asynchronous, active-high reset
//  exc_valid    in  1   exception reported this cycle (from Exception_Caught)
//  exc_cause    in  1   0=overflow, 1=illegal opcode (from Cause)
//  exc_pc       in  DW  PC of faulting instruction
//  ret_valid    in  1   return-from-exception decoded in ID
//  flush        out 2   WhichFlush encoding: 00 none, 01 IF/ID, 10 IF/ID+ID/EX, 11 IF/ID+ID/EX+EX/MEM
//  pc_sel       out 1   1 = PC takes pc_vector this cycle
//  pc_vector    out DW  redirect target
//  pc_hold      out 1   1 = freeze PC/IF_ID during flush
//  epc          out DW  saved exception PC
//  cause_reg    out 1   saved cause
//  in_handler   out 1   handler running
//  fatal        out 1   sticky: exception raised while in handler
//  exc_count    out 8   saturating count of accepted exceptions
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, flush=00, pc_sel=0, pc_vector=0, pc_hold=0, epc=0,
//   cause_reg=0, in_handler=0, fatal=0, exc_count=0, flush counter=0. Reset mid-sequence aborts.
//  States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT.
//  IDLE: exc_valid=1 at edge -> epc<=exc_pc, cause_reg<=exc_cause, exc_count+=1 (saturate 255),
//   cnt<=FLUSH_CYCLES-1, go FLUSH. ret_valid in IDLE ignored.
//  FLUSH: flush=11, pc_hold=1; cnt decrements each cycle; at cnt==0 go REDIRECT. Exactly
//   FLUSH_CYCLES cycles of flush=11. exc_valid ignored (younger instrs are being flushed).
//  REDIRECT: one cycle, pc_sel=1, pc_vector=VEC_OVF or VEC_OPC by cause_reg, flush=01; -> HANDLER.
//   First flush=11 cycle is the cycle after exc_valid sampled; redirect latency = FLUSH_CYCLES+1.
//  HANDLER: in_handler=1, outputs otherwise idle. ret_valid -> RETURN. exc_valid -> fatal<=1,
//   go HALT (epc/cause_reg NOT overwritten). If both same cycle, exc_valid wins (HALT).
//  RETURN: one cycle, pc_sel=1, pc_vector=epc+1 (mod 2^DW, wraps FFFF->0000), flush=01,
//   in_handler=1; -> IDLE. exc_valid in RETURN ignored.
//  HALT: pc_hold=1, fatal=1, flush=11 continuously; left only by reset.
//  All outputs registered (Moore); pc_vector holds last value outside pc_sel cycles.
//  Illegal state encodings -> IDLE next cycle.
// TESTING
//  exc_valid=1,cause=0,pc=0x0040 -> 2 cycles flush=11/pc_hold=1, then pc_sel=1,pc_vector=FF00; epc=0040.
//  cause=1,pc=0x0123, then ret_valid 5 cycles later -> vector FF80; RETURN cycle pc_vector=0124.
//  exc_pc=FFFF, then return -> pc_vector=0000 (wrap).
//  in HANDLER, exc_valid & ret_valid same cycle -> HALT, fatal=1, epc unchanged, flush stays 11.
//  rst pulsed mid-FLUSH (async, between edges) -> all outputs 0 immediately; next exception restarts cleanly.
//  300 exception/return sequences -> exc_count saturates at 0xFF.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// Exception report / redirect bundle between the hazard unit, exception_ctrl and the PC mux.
// slave = exception_ctrl side, master = the driving pipeline side.
interface exception_ctrl_if #(
  parameter int unsigned DW = 16
);
  logic          exc_valid;
  logic          exc_cause;
  logic [DW-1:0] exc_pc;
  logic          ret_valid;
  logic [1:0]    flush;
  logic          pc_sel;
  logic [DW-1:0] pc_vector;
  logic          pc_hold;
  logic [DW-1:0] epc;
  logic          cause_reg;
  logic          in_handler;
  logic          fatal;
  logic [7:0]    exc_count;

  modport slave (
    input  exc_valid, exc_cause, exc_pc, ret_valid,
    output flush, pc_sel, pc_vector, pc_hold, epc, cause_reg, in_handler, fatal, exc_count
  );

  modport master (
    output exc_valid, exc_cause, exc_pc, ret_valid,
    input  flush, pc_sel, pc_vector, pc_hold, epc, cause_reg, in_handler, fatal, exc_count
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception sequencer: latches EPC/cause, holds a pipeline flush, redirects fetch to the
// handler vector and restores EPC+1 on return. Nested exceptions park the core in HALT.
module exception_ctrl #(
  parameter int unsigned    DW           = 16,
  parameter logic [DW-1:0]  VEC_OVF      = 16'hFF00,
  parameter logic [DW-1:0]  VEC_OPC      = 16'hFF80,
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  exception_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_REDIRECT = 3'd2,
    S_HANDLER  = 3'd3,
    S_RETURN   = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_epc, w_epc_nxt;
  logic          r_cause, w_cause_nxt;
  logic [7:0]    r_count, w_count_nxt;
  logic          r_fatal, w_fatal_nxt;
  logic [1:0]    r_flush, w_flush_nxt;
  logic          r_pc_sel, w_pc_sel_nxt;
  logic [DW-1:0] r_pc_vector, w_pc_vector_nxt;
  logic          r_pc_hold, w_pc_hold_nxt;
  logic          r_in_handler, w_in_handler_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_epc_nxt   = r_epc;
    w_cause_nxt = r_cause;
    w_count_nxt = r_count;
    w_fatal_nxt = r_fatal;
    case (r_state)
      S_IDLE: begin
        if (bus.exc_valid) begin
          w_epc_nxt   = bus.exc_pc;
          w_cause_nxt = bus.exc_cause;
          w_count_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
          w_cnt_nxt   = 3'(FLUSH_CYCLES - 1);
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 3'd0) w_state_nxt = S_REDIRECT;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_REDIRECT: w_state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (bus.exc_valid) begin
          w_fatal_nxt = 1'b1;
          w_state_nxt = S_HALT;
        end else if (bus.ret_valid) begin
          w_state_nxt = S_RETURN;
        end
      end
      S_RETURN: w_state_nxt = S_IDLE;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state's own cycle.
  always_comb begin
    w_flush_nxt      = 2'b00;
    w_pc_sel_nxt     = 1'b0;
    w_pc_vector_nxt  = r_pc_vector;
    w_pc_hold_nxt    = 1'b0;
    w_in_handler_nxt = 1'b0;
    case (w_state_nxt)
      S_FLUSH: begin
        w_flush_nxt   = 2'b11;
        w_pc_hold_nxt = 1'b1;
      end
      S_REDIRECT: begin
        w_flush_nxt     = 2'b01;
        w_pc_sel_nxt    = 1'b1;
        w_pc_vector_nxt = w_cause_nxt ? VEC_OPC : VEC_OVF;
      end
      S_HANDLER: w_in_handler_nxt = 1'b1;
      S_RETURN: begin
        w_flush_nxt      = 2'b01;
        w_pc_sel_nxt     = 1'b1;
        w_pc_vector_nxt  = w_epc_nxt + DW'(1);
        w_in_handler_nxt = 1'b1;
      end
      S_HALT: begin
        w_flush_nxt   = 2'b11;
        w_pc_hold_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_epc        <= '0;
      r_cause      <= 1'b0;
      r_count      <= '0;
      r_fatal      <= 1'b0;
      r_flush      <= '0;
      r_pc_sel     <= 1'b0;
      r_pc_vector  <= '0;
      r_pc_hold    <= 1'b0;
      r_in_handler <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_epc        <= w_epc_nxt;
      r_cause      <= w_cause_nxt;
      r_count      <= w_count_nxt;
      r_fatal      <= w_fatal_nxt;
      r_flush      <= w_flush_nxt;
      r_pc_sel     <= w_pc_sel_nxt;
      r_pc_vector  <= w_pc_vector_nxt;
      r_pc_hold    <= w_pc_hold_nxt;
      r_in_handler <= w_in_handler_nxt;
    end
  end

  assign bus.flush      = r_flush;
  assign bus.pc_sel     = r_pc_sel;
  assign bus.pc_vector  = r_pc_vector;
  assign bus.pc_hold    = r_pc_hold;
  assign bus.epc        = r_epc;
  assign bus.cause_reg  = r_cause;
  assign bus.in_handler = r_in_handler;
  assign bus.fatal      = r_fatal;
  assign bus.exc_count  = r_count;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: flush/redirect timing, return wrap, nested HALT,
// async reset mid-flush and exc_count saturation.
module tb_exception_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_count = 0;

  exception_ctrl_if #(.DW(DW)) bus ();

  exception_ctrl #(
    .DW(DW), .VEC_OVF(16'hFF00), .VEC_OPC(16'hFF80), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flush"},  32'(bus.flush), 0);
    check({tag, ".pcsel"},  32'(bus.pc_sel), 0);
    check({tag, ".vec"},    32'(bus.pc_vector), 0);
    check({tag, ".hold"},   32'(bus.pc_hold), 0);
    check({tag, ".epc"},    32'(bus.epc), 0);
    check({tag, ".cause"},  32'(bus.cause_reg), 0);
    check({tag, ".inh"},    32'(bus.in_handler), 0);
    check({tag, ".fatal"},  32'(bus.fatal), 0);
    check({tag, ".count"},  32'(bus.exc_count), 0);
  endtask

  // Raise one exception from IDLE and follow it into HANDLER.
  task automatic enter_handler(input logic cause, input logic [DW-1:0] pc, input logic noise);
    bus.exc_valid = 1'b1;
    bus.exc_cause = cause;
    bus.exc_pc    = pc;
    tick();
    if (exp_count < 255) exp_count++;
    // optional second report during flush must be ignored
    bus.exc_valid = noise;
    bus.exc_cause = ~cause;
    bus.exc_pc    = ~pc;
    for (int i = 0; i < int'(FC); i++) begin
      check("flush.flush", 32'(bus.flush), 3);
      check("flush.hold",  32'(bus.pc_hold), 1);
      check("flush.pcsel", 32'(bus.pc_sel), 0);
      check("flush.epc",   32'(bus.epc), 32'(pc));
      check("flush.cause", 32'(bus.cause_reg), 32'(cause));
      check("flush.count", 32'(bus.exc_count), exp_count);
      tick();
      bus.exc_valid = 1'b0;
    end
    check("redir.pcsel", 32'(bus.pc_sel), 1);
    check("redir.vec",   32'(bus.pc_vector), cause ? 32'hFF80 : 32'hFF00);
    check("redir.flush", 32'(bus.flush), 1);
    check("redir.hold",  32'(bus.pc_hold), 0);
    tick();
    check("hand.inh",   32'(bus.in_handler), 1);
    check("hand.pcsel", 32'(bus.pc_sel), 0);
    check("hand.flush", 32'(bus.flush), 0);
    check("hand.vec",   32'(bus.pc_vector), cause ? 32'hFF80 : 32'hFF00);
  endtask

  task automatic do_return(input logic [DW-1:0] exp_vec, input logic exc_in_ret);
    bus.ret_valid = 1'b1;
    tick();
    bus.ret_valid = 1'b0;
    bus.exc_valid = exc_in_ret;
    check("ret.pcsel", 32'(bus.pc_sel), 1);
    check("ret.vec",   32'(bus.pc_vector), 32'(exp_vec));
    check("ret.flush", 32'(bus.flush), 1);
    check("ret.inh",   32'(bus.in_handler), 1);
    tick();
    bus.exc_valid = 1'b0;
    check("idle.pcsel", 32'(bus.pc_sel), 0);
    check("idle.inh",   32'(bus.in_handler), 0);
    check("idle.flush", 32'(bus.flush), 0);
    check("idle.count", 32'(bus.exc_count), exp_count);
  endtask

  initial begin
    bus.exc_valid = 1'b0;
    bus.exc_cause = 1'b0;
    bus.exc_pc    = '0;
    bus.ret_valid = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // return request while idle is ignored
    bus.ret_valid = 1'b1;
    tick();
    bus.ret_valid = 1'b0;
    check("idle_ret.pcsel", 32'(bus.pc_sel), 0);
    check("idle_ret.inh",   32'(bus.in_handler), 0);

    enter_handler(1'b0, 16'h0040, 1'b0);
    do_return(16'h0041, 1'b0);

    enter_handler(1'b1, 16'h0123, 1'b1);
    repeat (4) tick();
    check("hand5.inh", 32'(bus.in_handler), 1);
    do_return(16'h0124, 1'b1);

    enter_handler(1'b0, 16'hFFFF, 1'b0);
    do_return(16'h0000, 1'b0);

    // nested exception together with return: HALT wins
    enter_handler(1'b0, 16'h0200, 1'b0);
    bus.exc_valid = 1'b1;
    bus.exc_cause = 1'b1;
    bus.exc_pc    = 16'h0999;
    bus.ret_valid = 1'b1;
    tick();
    bus.exc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt.fatal", 32'(bus.fatal), 1);
      check("halt.flush", 32'(bus.flush), 3);
      check("halt.hold",  32'(bus.pc_hold), 1);
      check("halt.pcsel", 32'(bus.pc_sel), 0);
      check("halt.epc",   32'(bus.epc), 32'h0200);
      check("halt.cause", 32'(bus.cause_reg), 0);
      check("halt.count", 32'(bus.exc_count), exp_count);
      tick();
    end
    bus.ret_valid = 1'b0;

    // async reset out of HALT, then reset mid-flush
    #2 rst = 1'b1;
    #1 check_all_zero("rst_halt");
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    bus.exc_valid = 1'b1;
    bus.exc_cause = 1'b1;
    bus.exc_pc    = 16'h0300;
    tick();
    bus.exc_valid = 1'b0;
    check("preflush.flush", 32'(bus.flush), 3);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_flush");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst.flush", 32'(bus.flush), 0);
    enter_handler(1'b1, 16'h0500, 1'b0);
    do_return(16'h0501, 1'b0);

    for (int n = 0; n < 300; n++) begin
      enter_handler(n[0], 16'(n * 7), 1'b0);
      do_return(16'(n * 7 + 1), 1'b0);
    end
    check("sat.count", 32'(bus.exc_count), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
